// File: rtl/fft_mem_sched.sv
// fft_mem_sched: frame scheduler and write-port arbiter for the 16-point FFT working memory
module fft_mem_sched #(
    parameter int NPT = 16,
    parameter int NSTG = 4,
    parameter int DP_LAT = 4,
    parameter int AW = 7
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iCLR,
    input  logic                   iIN_VALID,
    output logic                   oIN_READY,
    output logic                   oSTART,
    input  logic                   iRD_EN,
    input  logic [2:0]             iRD_STAGE,
    output logic                   oWE,
    output logic [AW-1:0]          oWADDR,
    output logic                   oWSEL,
    output logic                   oOUT_VALID,
    output logic [$clog2(NPT)-1:0] oOUT_IDX,
    output logic                   oDONE,
    output logic                   oBUSY
);
    localparam int CW = $clog2(NPT);
    localparam int DL = DP_LAT - 1;
    localparam logic [2:0] LAST = 3'(NSTG);
    localparam logic [1:0] S_LOAD = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2;
    logic [1:0] state;
    logic [CW-1:0] loadCnt, wbCnt;
    logic [DL-1:0] dlEn;
    logic [DL-1:0][2:0] dlStg;
    logic [2:0] tailStg;
    logic wbIssue, outIssue, accept;
    assign tailStg = dlStg[DL-1];
    assign wbIssue = dlEn[DL-1] && tailStg != 3'd0 && tailStg < LAST;
    assign outIssue = dlEn[DL-1] && tailStg == LAST;
    // only memory write-backs contend with loads; final-stage outputs bypass the port
    assign oIN_READY = state == S_LOAD && !wbIssue;
    assign accept = iIN_VALID && oIN_READY && !iCLR;
    assign oSTART = state == S_ARM && iRD_STAGE == 3'd0 && dlEn == '0 && !iCLR;
    assign oBUSY = state != S_LOAD;
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            {state, loadCnt, wbCnt, dlEn, dlStg} <= '0;
            {oWE, oWSEL, oWADDR, oOUT_VALID, oOUT_IDX, oDONE} <= '0;
        end else if (iCLR) begin
            {state, loadCnt, wbCnt, dlEn, dlStg} <= '0;
            {oWE, oWSEL, oWADDR, oOUT_VALID, oOUT_IDX, oDONE} <= '0;
        end else begin
            dlEn <= DL'({dlEn, iRD_EN});
            dlStg <= (DL*3)'({dlStg, iRD_STAGE});
            oWE <= wbIssue || accept;
            oWSEL <= wbIssue;
            oWADDR <= wbIssue ? {(AW-CW)'(tailStg), wbCnt} : {{(AW-CW){1'b0}}, loadCnt};
            oOUT_VALID <= outIssue;
            oOUT_IDX <= outIssue ? wbCnt : '0;
            oDONE <= outIssue && wbCnt == CW'(NPT-1);
            if (wbIssue || outIssue) wbCnt <= wbCnt + 1'b1;
            if (accept) loadCnt <= loadCnt + 1'b1;
            state <= (state == S_LOAD && accept && loadCnt == CW'(NPT-1)) ? S_ARM :
                     oSTART ? S_RUN :
                     (state == S_RUN && iRD_STAGE >= 3'd2) ? S_LOAD : state;
        end
    end
endmodule

// File: tb/tb_fft_mem_sched.sv
// tb_fft_mem_sched: directed stimulus against a cycle-history model of the scheduler
module tb_fft_mem_sched;
    localparam int DP_LAT = 4;
    logic iCLK = 0, iRST, iCLR, iIN_VALID, iRD_EN;
    logic [2:0] iRD_STAGE;
    logic oIN_READY, oSTART, oWE, oWSEL, oOUT_VALID, oDONE, oBUSY;
    logic [6:0] oWADDR;
    logic [3:0] oOUT_IDX;
    int checks = 0, failures = 0, cyc = 0, lastClr = 0;
    logic hEn [8192];
    logic [2:0] hStg [8192];
    int mSt = 0, mLoad = 0, mWb = 0, eAddr = 0, eIdx = 0;
    logic eWe = 0, eSel = 0, eOv = 0, eDone = 0;
    int loadQ[$], wbQ[$], outQ[$];
    int startCnt = 0, doneCnt = 0, acc = 0, firstRd = -1, firstWb = -1, nWb, nLd;

    always #5 iCLK = ~iCLK;

    fft_mem_sched dut (
        .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iIN_VALID(iIN_VALID), .oIN_READY(oIN_READY),
        .oSTART(oSTART), .iRD_EN(iRD_EN), .iRD_STAGE(iRD_STAGE), .oWE(oWE), .oWADDR(oWADDR),
        .oWSEL(oWSEL), .oOUT_VALID(oOUT_VALID), .oOUT_IDX(oOUT_IDX), .oDONE(oDONE), .oBUSY(oBUSY)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // a read issued at cycle k survives only if no reset/clear happened at or after k
    function automatic logic vld(input int k);
        return k > lastClr && hEn[k];
    endfunction

    always @(negedge iCLK) begin
        int t;
        logic tw, to, anyV, eRdy, eStart, accM;
        hEn[cyc] = iRD_EN;
        hStg[cyc] = iRD_STAGE;
        t = cyc - (DP_LAT - 1);
        tw = vld(t) && hStg[t] != 0 && hStg[t] < 4;
        to = vld(t) && hStg[t] == 4;
        anyV = 0;
        for (int k = t; k < cyc; k++) anyV |= vld(k);
        eRdy = mSt == 0 && !tw;
        eStart = mSt == 1 && iRD_STAGE == 0 && !anyV && !iCLR && !iRST;
        chk("in_ready", oIN_READY, eRdy);
        chk("start", oSTART, eStart);
        chk("busy", oBUSY, mSt != 0);
        chk("we", oWE, eWe);
        chk("out_valid", oOUT_VALID, eOv);
        chk("done", oDONE, eDone);
        if (eWe || iRST) begin
            chk("wsel", oWSEL, eSel);
            chk("waddr", oWADDR, eAddr);
        end
        if (eOv || iRST) chk("out_idx", oOUT_IDX, eIdx);
        if (!iRST) begin
            if (oWE && !oWSEL) loadQ.push_back(oWADDR);
            if (oWE && oWSEL) begin
                wbQ.push_back(oWADDR);
                if (firstWb < 0) firstWb = cyc;
            end
            if (oOUT_VALID) outQ.push_back(oOUT_IDX);
            if (oDONE) doneCnt++;
            if (oSTART) startCnt++;
            if (iRD_EN && iRD_STAGE == 1 && firstRd < 0) firstRd = cyc;
            if (iIN_VALID && oIN_READY && !iCLR) acc++;
        end
        if (iRST || iCLR) begin
            mSt = 0; mLoad = 0; mWb = 0; eAddr = 0; eIdx = 0;
            eWe = 0; eSel = 0; eOv = 0; eDone = 0;
            lastClr = cyc;
        end else begin
            accM = iIN_VALID && eRdy;
            eWe = tw || accM;
            eSel = tw;
            eOv = to;
            eDone = to && mWb == 15;
            if (tw) eAddr = hStg[t] * 16 + mWb;
            else if (accM) eAddr = mLoad;
            if (to) eIdx = mWb;
            if (mSt == 0 && accM && mLoad == 15) mSt = 1;
            else if (eStart) mSt = 2;
            else if (mSt == 2 && iRD_STAGE >= 2) mSt = 0;
            if (tw || to) mWb = (mWb + 1) % 16;
            if (accM) mLoad = (mLoad + 1) % 16;
        end
        cyc++;
    end

    task automatic step(input logic v, input logic e, input logic [2:0] s, input logic c);
        iIN_VALID = v; iRD_EN = e; iRD_STAGE = s; iCLR = c;
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        iRST = 1; iCLR = 0; iIN_VALID = 0; iRD_EN = 0; iRD_STAGE = 0;
        repeat (3) @(posedge iCLK);
        #1 iRST = 0;
        chk("rst_ready", oIN_READY, 1);
        chk("rst_we", oWE, 0);
        chk("rst_busy", oBUSY, 0);
        repeat (16) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("f1_loads", loadQ.size(), 16);
        for (int i = 0; i < 16; i++) chk("f1_load_addr", loadQ[i], i);
        chk("f1_start", startCnt, 1);
        chk("f1_busy", oBUSY, 1);
        repeat (16) step(0, 1, 1, 0);
        for (int i = 0; i < 32; i++) step(acc < 32, i % 2 == 0, 2, 0);
        for (int i = 0; i < 16; i++) step(acc < 32, 1, 3, 0);
        for (int i = 0; i < 16; i++) step(acc < 32, 1, 4, 0);
        for (int i = 0; i < 40; i++) step(acc < 32, 0, 0, 0);
        chk("wb_latency", firstWb - firstRd, 4);
        chk("wb_count", wbQ.size(), 48);
        for (int i = 0; i < 48; i++) chk("wb_addr", wbQ[i], 16 + i);
        chk("out_count", outQ.size(), 16);
        for (int i = 0; i < 16; i++) chk("out_idx_seq", outQ[i], i);
        chk("done_count", doneCnt, 1);
        chk("f2_loads", loadQ.size(), 32);
        for (int i = 0; i < 16; i++) chk("f2_load_addr", loadQ[16 + i], i);
        chk("f2_start", startCnt, 2);
        step(0, 0, 2, 0);
        repeat (7) step(1, 0, 2, 0);
        repeat (3) step(0, 1, 2, 0);
        nWb = wbQ.size();
        nLd = loadQ.size();
        step(1, 0, 0, 1);
        chk("clr_ready", oIN_READY, 1);
        repeat (5) step(0, 0, 0, 0);
        chk("clr_no_wb", wbQ.size(), nWb);
        chk("clr_no_load", loadQ.size(), nLd);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("clr_load_count", loadQ.size(), nLd + 1);
        chk("clr_load_addr", loadQ[loadQ.size() - 1], 0);
        repeat (3) step(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
